// File: rtl/kahve_siparis_kontrol_if.sv
// kahve_siparis_kontrol_if
// Bundles the order/brewer/service-counter handshake of the coffee order
// controller.
//   master : user/brewer/service-counter side. Drives the requests and
//            completions, observes the controller outputs.
//   slave  : the controller itself.
// Signals:
//   siparis, siparis_tipi[1:0]   order request and order type
//   demleme_bitti                brewer done
//   bitti, bosalt                service counter done / bin-full request
//   bosalt_onay                  operator emptied the grounds bin
//   hazir, demle, basla          idle, heater enable, start command
//   demlendi, filtrele, filtre_tipi  command qualifiers, valid with basla
//   bosaltma_bekle, hata         waiting for operator, error pulse
//   servis_sayisi[7:0]           completed service count
interface kahve_siparis_kontrol_if;
  logic       siparis;
  logic [1:0] siparis_tipi;
  logic       demleme_bitti;
  logic       bitti;
  logic       bosalt;
  logic       bosalt_onay;
  logic       hazir;
  logic       demle;
  logic       basla;
  logic       demlendi;
  logic       filtrele;
  logic       filtre_tipi;
  logic       bosaltma_bekle;
  logic       hata;
  logic [7:0] servis_sayisi;

  modport master (
    output siparis, siparis_tipi, demleme_bitti, bitti, bosalt, bosalt_onay,
    input  hazir, demle, basla, demlendi, filtrele, filtre_tipi,
           bosaltma_bekle, hata, servis_sayisi
  );

  modport slave (
    input  siparis, siparis_tipi, demleme_bitti, bitti, bosalt, bosalt_onay,
    output hazir, demle, basla, demlendi, filtrele, filtre_tipi,
           bosaltma_bekle, hata, servis_sayisi
  );
endinterface

// File: rtl/kahve_siparis_kontrol.sv
// kahve_siparis_kontrol
// Coffee order controller. It accepts an order, runs the brewer under a
// timeout and issues a one-cycle start command to the service counter. It
// then waits for the counter to finish and, when the counter reports a full
// grounds bin, holds new orders until the operator confirms the bin is empty.
// Ports:
//   saat   : clock, rising edge
//   reset  : asynchronous active-low reset
//   bus    : order/brewer/service handshake (slave side of
//            kahve_siparis_kontrol_if)
// Parameter:
//   DEMLEME_ZAMAN_ASIMI : cycles the heater may stay on (1..255)
module kahve_siparis_kontrol #(
  parameter int unsigned DEMLEME_ZAMAN_ASIMI = 16
) (
  input  logic                    saat,
  input  logic                    reset,
  kahve_siparis_kontrol_if.slave  bus
);

  typedef enum logic [2:0] {
    BOSTA        = 3'd0,
    DEMLE        = 3'd1,
    SERVIS       = 3'd2,
    BEKLE        = 3'd3,
    BOSALT_BEKLE = 3'd4
  } durum_e;

  // Last counter value before timeout; the heater is on for counts 0..N-1.
  localparam logic [7:0] SON_SAYAC = 8'(DEMLEME_ZAMAN_ASIMI - 1);

  durum_e     durum_q, durum_d;
  logic [1:0] tip_q, tip_d;
  logic       demlendi_q, demlendi_d;
  logic [7:0] sayac_q, sayac_d;
  logic       hata_q, hata_d;
  logic [7:0] servis_q, servis_d;

  // State register and datapath flops.
  always_ff @(posedge saat or negedge reset) begin
    if (!reset) begin
      durum_q    <= BOSTA;
      tip_q      <= 2'b00;
      demlendi_q <= 1'b0;
      sayac_q    <= 8'd0;
      hata_q     <= 1'b0;
      servis_q   <= 8'd0;
    end else begin
      durum_q    <= durum_d;
      tip_q      <= tip_d;
      demlendi_q <= demlendi_d;
      sayac_q    <= sayac_d;
      hata_q     <= hata_d;
      servis_q   <= servis_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    durum_d    = durum_q;
    tip_d      = tip_q;
    demlendi_d = demlendi_q;
    sayac_d    = sayac_q;
    hata_d     = 1'b0;
    servis_d   = servis_q;
    case (durum_q)
      BOSTA: begin
        if (bus.siparis) begin
          if (bus.siparis_tipi == 2'b11) begin
            hata_d = 1'b1;
          end else begin
            tip_d   = bus.siparis_tipi;
            sayac_d = 8'd0;
            durum_d = DEMLE;
          end
        end else begin
          durum_d = BOSTA;
        end
      end
      DEMLE: begin
        // Brewer completion takes priority over a timeout on the same edge.
        if (bus.demleme_bitti) begin
          demlendi_d = 1'b1;
          durum_d    = SERVIS;
        end else if (sayac_q == SON_SAYAC) begin
          demlendi_d = 1'b0;
          hata_d     = 1'b1;
          durum_d    = SERVIS;
        end else begin
          sayac_d = sayac_q + 8'd1;
        end
      end
      SERVIS: begin
        durum_d = BEKLE;
      end
      BEKLE: begin
        if (bus.bitti) begin
          servis_d = servis_q + 8'd1;
          durum_d  = bus.bosalt ? BOSALT_BEKLE : BOSTA;
        end else begin
          durum_d = BEKLE;
        end
      end
      BOSALT_BEKLE: begin
        if (bus.bosalt_onay) begin
          durum_d = BOSTA;
        end else begin
          durum_d = BOSALT_BEKLE;
        end
      end
      default: begin
        durum_d = BOSTA;
      end
    endcase
  end

  // Outputs decode the state register; qualifiers are forced low outside SERVIS.
  assign bus.hazir          = (durum_q == BOSTA);
  assign bus.demle          = (durum_q == DEMLE);
  assign bus.basla          = (durum_q == SERVIS);
  assign bus.bosaltma_bekle = (durum_q == BOSALT_BEKLE);
  assign bus.demlendi       = (durum_q == SERVIS) & demlendi_q;
  assign bus.filtrele       = (durum_q == SERVIS) & (tip_q != 2'b00);
  assign bus.filtre_tipi    = (durum_q == SERVIS) & (tip_q == 2'b10);
  assign bus.hata           = hata_q;
  assign bus.servis_sayisi  = servis_q;

endmodule
